// File: rtl/freq_meter_multi.sv
// Multi-channel frequency meter: counts test_clk edges during an s_clk-timed gate window,
// with a toggle-ack handshake back from each test domain and per-channel status flags.
module freq_meter_multi #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int GW  = 16,
    parameter int TMO = 64
) (
    input  logic              s_clk,
    input  logic              arst,
    input  logic [NCH-1:0]    test_clk,
    input  logic              start,
    input  logic              continuous,
    input  logic [GW-1:0]     gate_len,
    input  logic [CW-1:0]     lim_lo,
    input  logic [CW-1:0]     lim_hi,
    output logic              busy,
    output logic              done,
    output logic [NCH*CW-1:0] cnt_out,
    output logic [NCH-1:0]    ovf,
    output logic [NCH-1:0]    dead,
    output logic [NCH-1:0]    in_range
);

    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, ARM, GATE, DRAIN, CAPTURE} state_t;

    state_t              state_q;
    logic [GW-1:0]       len_q;
    logic                cont_q;
    logic [1:0]          armCnt_q;
    logic [GW-1:0]       gateCnt_q;
    logic                gate_q;
    logic [TW-1:0]       tmoCnt_q;
    logic [NCH-1:0]      ackMeta_q;
    logic [NCH-1:0]      ackSync_q;
    logic [NCH-1:0]      ackRef_q;
    logic                busy_q;
    logic                done_q;
    logic [NCH*CW-1:0]   cntOut_q;
    logic [NCH-1:0]      ovf_q;
    logic [NCH-1:0]      dead_q;
    logic [NCH-1:0]      inRange_q;

    logic [NCH*CW-1:0]   cntT;
    logic [NCH-1:0]      ovfT;
    logic [NCH-1:0]      ackT;
    logic [NCH-1:0]      acked;

    logic [NCH*CW-1:0]   capCnt;
    logic [NCH-1:0]      capOvf;
    logic [NCH-1:0]      capDead;
    logic [NCH-1:0]      capInRange;
    logic [CW-1:0]       chCnt;

    // Per-channel test-domain logic: gate synchroniser, edge counter and ack toggle.
    for (genvar i = 0; i < NCH; i++) begin : gChan
        logic [1:0]    gateSync_q;
        logic          gatePrev_q;
        logic [CW-1:0] cnt_q;
        logic          ovfT_q;
        logic          ack_q;
        logic          gateT;
        logic          rise;
        logic          fall;

        assign gateT = gateSync_q[1];
        assign rise  = gateT & ~gatePrev_q;
        assign fall  = ~gateT & gatePrev_q;

        always_ff @(posedge test_clk[i] or posedge arst) begin
            if (arst) begin
                gateSync_q <= '0;
                gatePrev_q <= 1'b0;
                cnt_q      <= '0;
                ovfT_q     <= 1'b0;
                ack_q      <= 1'b0;
            end else begin
                gateSync_q <= {gateSync_q[0], gate_q};
                gatePrev_q <= gateT;
                if (rise) begin
                    cnt_q  <= CW'(1);
                    ovfT_q <= 1'b0;
                end else if (gateT) begin
                    if (cnt_q == '1)
                        ovfT_q <= 1'b1;
                    else
                        cnt_q <= cnt_q + 1'b1;
                end
                if (fall)
                    ack_q <= ~ack_q;
            end
        end

        assign cntT[i*CW +: CW] = cnt_q;
        assign ovfT[i]          = ovfT_q;
        assign ackT[i]          = ack_q;
    end

    // Bring the ack toggles back into s_clk; a channel has answered once its toggle moved.
    always_ff @(posedge s_clk or posedge arst) begin
        if (arst) begin
            ackMeta_q <= '0;
            ackSync_q <= '0;
        end else begin
            ackMeta_q <= ackT;
            ackSync_q <= ackMeta_q;
        end
    end

    assign acked = ackSync_q ^ ackRef_q;

    // Test-domain counters are frozen once their ack is seen, so sampling them directly is safe.
    always_comb begin
        capCnt     = '0;
        capOvf     = '0;
        capDead    = '0;
        capInRange = '0;
        chCnt      = '0;
        for (int i = 0; i < NCH; i++) begin
            chCnt = cntT[i*CW +: CW];
            if (acked[i]) begin
                capCnt[i*CW +: CW] = chCnt;
                capOvf[i]          = ovfT[i];
                capInRange[i]      = !ovfT[i] && (chCnt >= lim_lo) && (chCnt <= lim_hi);
            end else begin
                capDead[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge s_clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cont_q    <= 1'b0;
            armCnt_q  <= '0;
            gateCnt_q <= '0;
            gate_q    <= 1'b0;
            tmoCnt_q  <= '0;
            ackRef_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cntOut_q  <= '0;
            ovf_q     <= '0;
            dead_q    <= '0;
            inRange_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q    <= (gate_len == '0) ? GW'(1) : gate_len;
                        cont_q   <= continuous;
                        busy_q   <= 1'b1;
                        armCnt_q <= '0;
                        state_q  <= ARM;
                    end
                end
                ARM: begin
                    armCnt_q <= armCnt_q + 1'b1;
                    if (armCnt_q == 2'd3) begin
                        ackRef_q  <= ackSync_q;
                        gateCnt_q <= len_q;
                        gate_q    <= 1'b1;
                        state_q   <= GATE;
                    end
                end
                GATE: begin
                    if (gateCnt_q == GW'(1)) begin
                        gate_q   <= 1'b0;
                        tmoCnt_q <= '0;
                        state_q  <= DRAIN;
                    end else begin
                        gateCnt_q <= gateCnt_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if ((&acked) || (tmoCnt_q == TW'(TMO - 1)))
                        state_q <= CAPTURE;
                    else
                        tmoCnt_q <= tmoCnt_q + 1'b1;
                end
                CAPTURE: begin
                    cntOut_q  <= capCnt;
                    ovf_q     <= capOvf;
                    dead_q    <= capDead;
                    inRange_q <= capInRange;
                    done_q    <= 1'b1;
                    // Dropping continuous mid-run ends the loop after this capture.
                    if (cont_q && continuous) begin
                        armCnt_q <= '0;
                        state_q  <= ARM;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cnt_out  = cntOut_q;
    assign ovf      = ovf_q;
    assign dead     = dead_q;
    assign in_range = inRange_q;

endmodule
